mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared program/data memory (AWIDTH=5, DWIDTH=8). Port C is the CPU (fetch/operand/store). Port L is the program loader/debug port. The block serialises accesses and drives the memory's rd/wr strobes, address, write data and data-driver enable. It captures read data and returns it with a per-port valid pulse.

---
 rtl/risc_pkg.sv | 17 +
 rtl/arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the memory arbiter slice:
// FSM state encodings, port indices and default bus widths.
package risc_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way request picker: returns a one-hot winner
// from the req vector, the served-port mask and last_gnt.
module arb_pick
    import risc_pkg::*;
#(
    parameter bit CPU_PRIORITY = 1'b0
) (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_gnt,
    output logic [1:0] win
);

    logic [1:0] cand;

    // Mask steers away from the port just served; a lone
    // requester still wins so it can stream back-to-back.
    always_comb begin
        cand = req & ~mask;
        if (cand == 2'b00) begin
            cand = req;
        end
        win = 2'b00;
        if (CPU_PRIORITY) begin
            if (req[PORT_C]) begin
                win[PORT_C] = 1'b1;
            end else if (req[PORT_L]) begin
                win[PORT_L] = 1'b1;
            end
        end else if (cand == 2'b11) begin
            win = (last_gnt == PORT_C) ? 2'b10 : 2'b01;
        end else begin
            win = cand;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and loader accesses onto the shared memory,
// drives strobes/address/data and returns captured read data.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int AWIDTH       = AWIDTH_DEF,
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter bit CPU_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [AWIDTH-1:0] c_addr,
    input  logic [DWIDTH-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [AWIDTH-1:0] l_addr,
    input  logic [DWIDTH-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DWIDTH-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_data_e,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    state_t            state_n;
    logic              last_gnt;
    logic              last_gnt_n;
    logic [1:0]        req;
    logic [1:0]        mask;
    logic [1:0]        win;
    logic              grant_ok;
    logic              go;
    logic              sel_l;
    logic              sel_we;
    logic              rd_done;
    logic              c_gnt_n;
    logic              l_gnt_n;
    logic              c_rvalid_n;
    logic              l_rvalid_n;
    logic [DWIDTH-1:0] rdata_n;
    logic              mem_rd_n;
    logic              mem_wr_n;
    logic [AWIDTH-1:0] mem_addr_n;
    logic [DWIDTH-1:0] mem_wdata_n;
    logic              busy_n;

    assign req      = {l_req, c_req};
    assign mask     = (state == ST_ACCESS) ? {l_gnt, c_gnt} : 2'b00;
    assign grant_ok = (state == ST_IDLE) ||
                      ((state == ST_ACCESS) && !mem_wr);
    assign go       = grant_ok && (win != 2'b00);

    arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_pick (
        .req      (req),
        .mask     (mask),
        .last_gnt (last_gnt),
        .win      (win)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: writes always pay a TURN cycle
    always_comb begin
        state_n = ST_IDLE;
        unique case (state)
            ST_IDLE: begin
                state_n = go ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (mem_wr) begin
                    state_n = ST_TURN;
                end else begin
                    state_n = go ? ST_ACCESS : ST_IDLE;
                end
            end
            ST_TURN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Next output values for the coming cycle
    always_comb begin
        sel_l       = win[PORT_L];
        sel_we      = sel_l ? l_we : c_we;
        c_gnt_n     = go & win[PORT_C];
        l_gnt_n     = go & sel_l;
        mem_rd_n    = go & ~sel_we;
        mem_wr_n    = go & sel_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if (go) begin
            mem_addr_n  = sel_l ? l_addr : c_addr;
            mem_wdata_n = sel_l ? l_wdata : c_wdata;
        end
        rd_done    = (state == ST_ACCESS) & mem_rd;
        c_rvalid_n = rd_done & c_gnt;
        l_rvalid_n = rd_done & l_gnt;
        rdata_n    = rd_done ? mem_rdata : rdata;
        busy_n     = (state_n != ST_IDLE);
        last_gnt_n = go ? sel_l : last_gnt;
    end

    // Output and arbitration-history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_gnt      <= 1'b0;
            l_gnt      <= 1'b0;
            c_rvalid   <= 1'b0;
            l_rvalid   <= 1'b0;
            rdata      <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_data_e <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            last_gnt   <= PORT_L;
        end else begin
            c_gnt      <= c_gnt_n;
            l_gnt      <= l_gnt_n;
            c_rvalid   <= c_rvalid_n;
            l_rvalid   <= l_rvalid_n;
            rdata      <= rdata_n;
            mem_rd     <= mem_rd_n;
            mem_wr     <= mem_wr_n;
            mem_data_e <= mem_wr_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            busy       <= busy_n;
            last_gnt   <= last_gnt_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance plus a
// fixed-priority instance, read results checked via a queue.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       c_req;
    logic       c_we;
    logic [4:0] c_addr;
    logic [7:0] c_wdata;
    logic       l_req;
    logic       l_we;
    logic [4:0] l_addr;
    logic [7:0] l_wdata;

    logic       c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic       mem_rd, mem_wr, mem_data_e, busy;
    logic [4:0] mem_addr;

    logic       c_gnt2, c_rvalid2, l_gnt2, l_rvalid2;
    logic [7:0] rdata2, mem_wdata2, mem_rdata2;
    logic       mem_rd2, mem_wr2, mem_data_e2, busy2;
    logic [4:0] mem_addr2;

    logic [7:0] mem [32] = '{0: 8'h11, 1: 8'h22, 2: 8'h33,
                             3: 8'hA5, default: 8'h00};

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .CPU_PRIORITY(1'b0)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_e(mem_data_e), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .CPU_PRIORITY(1'b1)) dut_fix (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt2), .c_rvalid(c_rvalid2),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt2), .l_rvalid(l_rvalid2),
        .rdata(rdata2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_data_e(mem_data_e2), .mem_rdata(mem_rdata2), .busy(busy2)
    );

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];

    // Shared memory, written only by the round-robin instance
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        q.push_back(e);
    endtask

    // Advance one cycle, sample, and retire any read result
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("rd_de_overlap", {31'd0, mem_rd & mem_data_e}, 32'd0);
        if (c_rvalid || l_rvalid) begin
            if (q.size() == 0) begin
                chk("sb_extra_rvalid", {30'd0, l_rvalid, c_rvalid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_port", {30'd0, l_rvalid, c_rvalid},
                    e.port ? 32'd2 : 32'd1);
                chk("sb_rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    endtask

    function automatic logic [28:0] outs1();
        return {c_gnt, c_rvalid, l_gnt, l_rvalid, rdata, mem_rd, mem_wr,
                mem_addr, mem_wdata, mem_data_e, busy};
    endfunction

    function automatic logic [28:0] outs2();
        return {c_gnt2, c_rvalid2, l_gnt2, l_rvalid2, rdata2, mem_rd2,
                mem_wr2, mem_addr2, mem_wdata2, mem_data_e2, busy2};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = '0;
        c_wdata = '0;
        l_req   = 1'b0;
        l_we    = 1'b0;
        l_addr  = '0;
        l_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {3'd0, outs1()}, 32'd0);
        chk("reset_outs_fix", {3'd0, outs2()}, 32'd0);

        // CPU read of 0x03
        rst    = 1'b1;
        c_req  = 1'b1;
        c_addr = 5'h03;
        push(1'b0, 8'hA5);
        tick();
        chk("rd_c_gnt", {31'd0, c_gnt}, 32'd1);
        chk("rd_l_gnt", {31'd0, l_gnt}, 32'd0);
        chk("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("rd_mem_addr", {27'd0, mem_addr}, 32'h03);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        c_req = 1'b0;
        tick();
        chk("rd_done_busy", {31'd0, busy}, 32'd0);
        chk("rd_done_strobe", {31'd0, mem_rd}, 32'd0);

        // Loader write 0x10 <- 0x3C, then CPU reads it back
        l_req   = 1'b1;
        l_we    = 1'b1;
        l_addr  = 5'h10;
        l_wdata = 8'h3C;
        tick();
        chk("wr_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("wr_data_e", {31'd0, mem_data_e}, 32'd1);
        chk("wr_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("wr_addr", {27'd0, mem_addr}, 32'h10);
        chk("wr_wdata", {24'd0, mem_wdata}, 32'h3C);
        l_req  = 1'b0;
        l_we   = 1'b0;
        c_req  = 1'b1;
        c_addr = 5'h10;
        push(1'b0, 8'h3C);
        tick();
        chk("turn_wr", {31'd0, mem_wr | mem_data_e}, 32'd0);
        chk("turn_gnt", {30'd0, c_gnt, l_gnt}, 32'd0);
        chk("turn_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("post_turn_gnt", {31'd0, c_gnt}, 32'd0);
        chk("post_turn_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rb_c_gnt", {31'd0, c_gnt}, 32'd1);
        chk("rb_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("rb_addr", {27'd0, mem_addr}, 32'h10);
        c_req = 1'b0;
        tick();

        // Back-to-back CPU reads 0x00..0x03
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        push(1'b0, 8'h33);
        push(1'b0, 8'hA5);
        c_req  = 1'b1;
        c_addr = 5'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_gnt", {31'd0, c_gnt}, 32'd1);
            chk("b2b_addr", {27'd0, mem_addr}, i);
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            if (i < 3) c_addr = 5'(i + 1);
            else c_req = 1'b0;
        end
        tick();

        // Both ports hold reads: last grant was C, so L leads
        c_req  = 1'b1;
        c_addr = 5'h03;
        l_req  = 1'b1;
        l_addr = 5'h10;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(1'b1, 8'h3C);
            else push(1'b0, 8'hA5);
        end
        push(1'b1, 8'h3C);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_l_gnt", {31'd0, l_gnt}, (k % 2 == 0) ? 1 : 0);
            chk("rr_c_gnt", {31'd0, c_gnt}, (k % 2 == 0) ? 0 : 1);
            chk("fix_c_gnt", {31'd0, c_gnt2}, 32'd1);
            chk("fix_l_gnt", {31'd0, l_gnt2}, 32'd0);
        end
        c_req = 1'b0;
        tick();
        chk("rr_tail_l_gnt", {31'd0, l_gnt}, 32'd1);
        chk("fix_tail_l_gnt", {31'd0, l_gnt2}, 32'd1);
        chk("fix_tail_c_gnt", {31'd0, c_gnt2}, 32'd0);
        l_req = 1'b0;
        tick();
        tick();

        // Reset asserted inside a read grant cycle
        c_req  = 1'b1;
        c_addr = 5'h03;
        tick();
        chk("rst_pre_gnt", {31'd0, c_gnt}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_outs", {3'd0, outs1()}, 32'd0);
        chk("rst_async_outs_fix", {3'd0, outs2()}, 32'd0);
        c_req = 1'b0;
        tick();
        chk("rst_no_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_rel_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("sb_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
